controller: RTL and testbench
=============================

Name: controller

Overview:
- Main control decoder for the single-cycle RV32I-subset core.
- Takes the fetched instruction and the ALU zero flag, and produces datapath control: register/memory write enables, PC select, ALU operand select, immediate format, result mux select and the 3-bit ALU operation.
- Decode is purely combinational, in the same cycle as the instruction.
- One clocked element, a sticky illegal-instruction status flag, which uses the clock and reset.

Parameters:
- none

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high; clears the sticky status register only
- instr  input  32  current instruction word
- zero  input  1  ALU result-equals-zero flag from the datapath
- alucontrol  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- regwrite  output  1  register file write enable
- memwrite  output  1  data memory write enable
- pcsrc  output  1  1 = PC takes branch/jump target, 0 = PC+4
- alusrc  output  1  1 = ALU operand B is the immediate, 0 = rs2
- immsrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- resultsrc  output  2  writeback select: 00 ALU, 01 memory read data, 10 PC+4
- illegal  output  1  combinational: opcode/funct not supported
- illegal_seen  output  1  registered sticky OR of illegal; 0 after reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Fields decoded: op = instr[6:0], funct3 = instr[14:12], funct7b5 = instr[30]. All other bits are ignored.
- Main decoder, listed as regwrite, immsrc, alusrc, memwrite, resultsrc, branch, aluop, jump:
  - lw 0000011: 1, 00, 1, 0, 01, 0, 00, 0
  - sw 0100011: 0, 01, 1, 1, 00, 0, 00, 0
  - R-type 0110011: 1, 00, 0, 0, 00, 0, 10, 0
  - beq 1100011: 0, 10, 0, 0, 00, 1, 01, 0
  - I-ALU 0010011: 1, 00, 1, 0, 00, 0, 10, 0
  - jal 1101111: 1, 11, 0, 0, 10, 0, 00, 1
- Any other opcode: all outputs 0, branch = jump = 0, illegal = 1. Don't-care fields are driven to 0, never X.
- ALU decoder:
  - aluop 00 gives 000 (add); aluop 01 gives 001 (sub).
  - aluop 10, by funct3:
    - 000: sub (001) if op[5] and funct7b5 are both 1, else add (000).
    - 010: slt (101).
    - 110: or (011).
    - 111: and (010).
    - Any other funct3: alucontrol = 000, regwrite forced to 0, illegal = 1.
- beq with funct3 not equal to 000 is illegal: pcsrc = 0, illegal = 1.
- pcsrc = (branch AND zero) OR jump.
- All decode outputs are combinational, zero latency, and independent of clk/reset. Reset does not gate them.
- illegal_seen:
  - On a rising clk with reset = 1, it becomes 0.
  - Otherwise it becomes illegal_seen OR illegal.
  - If reset and illegal are both 1 on the same edge, reset wins.

Optional Feature:
- Macro: CONTROLLER_BNE_EN.
- Defined: opcode 1100011 with funct3 001 decodes as bne. It uses the same controls as beq (immsrc 10, aluop 01), pcsrc = branch AND NOT zero, and it is not illegal.
- Undefined: funct3 001 on the branch opcode is illegal, as stated above.

Decomposition:
- Shared package controller_pkg holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU, OP_JAL
  - ALU-op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - immsrc and resultsrc encodings
- One natural sub-module, alu_decoder: inputs op[5], funct3, funct7b5, aluop; outputs alucontrol and an illegal-funct flag. The main decoder and the sticky flag stay in controller.

Test Plan:
- instr=FF718393 (addi x7,x3,-9), zero=0 -> regwrite1 immsrc00 alusrc1 memwrite0 resultsrc00 pcsrc0 alucontrol000 illegal0.
- instr=0023E233 (or x4,x7,x2), zero=1 -> regwrite1 alusrc0 memwrite0 resultsrc00 pcsrc0 alucontrol011.
- instr=40208033 (sub) -> alucontrol001; instr=0020A033 (slt) -> 101; instr=0020F033 (and) -> 010.
- beq 00208463 with zero=1 -> pcsrc1, immsrc10, alucontrol001; same with zero=0 -> pcsrc0. jal 008000EF -> pcsrc1 resultsrc10 immsrc11 regwrite1.
- lw 0040A183 -> resultsrc01 alusrc1; sw 0030A223 -> memwrite1 immsrc01 regwrite0.
- instr=00000000 -> illegal1 with all enables 0; illegal_seen 1 after the next edge and held 1 on later legal instructions; reset=1 for one edge -> illegal_seen 0.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared decode constants and control-word layout for the RV32I-subset controller.
// The optional bne decode is enabled by defining CONTROLLER_BNE_EN.
package controller_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Field order matches the main-decoder table so rows can be written as concatenations.
  typedef struct packed {
    logic       regwrite;
    logic [1:0] immsrc;
    logic       alusrc;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic [1:0] aluop;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/controller_alu_decoder.sv
// ALU operation decoder: maps aluop/funct3/funct7b5 to the 3-bit ALU control
// and flags funct3 values the ALU cannot execute.
module alu_decoder
  import controller_pkg::*;
(
  input  logic       op_b5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [1:0] aluop_i,
  output logic [2:0] alucontrol_o,
  output logic       illegal_funct_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alucontrol_o    = ALU_ADD;
    illegal_funct_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (op_b5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b110:  alucontrol_o = ALU_OR;
          3'b111:  alucontrol_o = ALU_AND;
          default: illegal_funct_o = 1'b1;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Main control decoder for the single-cycle RV32I-subset core, plus a sticky
// illegal-instruction flag. Define CONTROLLER_BNE_EN to also decode bne.
module controller
  import controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [2:0]  alucontrol,
  output logic        regwrite,
  output logic        memwrite,
  output logic        pcsrc,
  output logic        alusrc,
  output logic [1:0]  immsrc,
  output logic [1:0]  resultsrc,
  output logic        illegal,
  output logic        illegal_seen
);

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  ctrl_t      ctrl;
  logic       op_illegal;
  logic       br_illegal;
  logic       is_bne;
  logic       funct_illegal;
  logic       branch_taken;
  logic       illegal_seen_d;
  logic       illegal_seen_q;
  logic       unused_instr;

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  // Register and immediate fields belong to the datapath, not to decode.
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    ctrl       = '0;
    op_illegal = 1'b0;
    br_illegal = 1'b0;
    is_bne     = 1'b0;
    case (op)
      OP_LOAD:   ctrl = {1'b1, IMM_I, 1'b1, 1'b0, RES_MEM, 1'b0, ALUOP_ADD,   1'b0};
      OP_STORE:  ctrl = {1'b0, IMM_S, 1'b1, 1'b1, RES_ALU, 1'b0, ALUOP_ADD,   1'b0};
      OP_RTYPE:  ctrl = {1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALUOP_FUNCT, 1'b0};
      OP_IALU:   ctrl = {1'b1, IMM_I, 1'b1, 1'b0, RES_ALU, 1'b0, ALUOP_FUNCT, 1'b0};
      OP_JAL:    ctrl = {1'b1, IMM_J, 1'b0, 1'b0, RES_PC4, 1'b0, ALUOP_ADD,   1'b1};
      OP_BRANCH: begin
        ctrl = {1'b0, IMM_B, 1'b0, 1'b0, RES_ALU, 1'b1, ALUOP_SUB, 1'b0};
`ifdef CONTROLLER_BNE_EN
        is_bne     = (funct3 == F3_BNE);
        br_illegal = (funct3 != F3_BEQ) && !is_bne;
`else
        br_illegal = (funct3 != F3_BEQ);
`endif
        // An unsupported compare must never redirect the PC.
        if (br_illegal) ctrl.branch = 1'b0;
      end
      default:   op_illegal = 1'b1;
    endcase
  end

  alu_decoder u_alu_decoder (
    .op_b5_i         (op[5]),
    .funct3_i        (funct3),
    .funct7b5_i      (funct7b5),
    .aluop_i         (ctrl.aluop),
    .alucontrol_o    (alucontrol),
    .illegal_funct_o (funct_illegal)
  );

  assign branch_taken = ctrl.branch & (is_bne ? ~zero : zero);
  assign pcsrc        = branch_taken | ctrl.jump;
  assign regwrite     = ctrl.regwrite & ~funct_illegal;
  assign memwrite     = ctrl.memwrite;
  assign alusrc       = ctrl.alusrc;
  assign immsrc       = ctrl.immsrc;
  assign resultsrc    = ctrl.resultsrc;
  assign illegal      = op_illegal | br_illegal | funct_illegal;

  assign illegal_seen_d = illegal_seen_q | illegal;

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    if (reset) illegal_seen_q <= 1'b0;
    else       illegal_seen_q <= illegal_seen_d;
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: table-driven decode vectors through a
// scoreboard queue, plus hand-written sequences for the sticky illegal flag.
module tb_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic [2:0]  alucontrol;
  logic        regwrite, memwrite, pcsrc, alusrc, illegal, illegal_seen;
  logic [1:0]  immsrc, resultsrc;

  always #5 clk = ~clk;

  controller dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .zero         (zero),
    .alucontrol   (alucontrol),
    .regwrite     (regwrite),
    .memwrite     (memwrite),
    .pcsrc        (pcsrc),
    .alusrc       (alusrc),
    .immsrc       (immsrc),
    .resultsrc    (resultsrc),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  // Packed output word: {regwrite, memwrite, pcsrc, alusrc, immsrc, resultsrc, alucontrol, illegal}
  typedef struct packed {
    logic [31:0] instr;
    logic        zero;
    logic [11:0] expct;
    logic [11:0] mask;
  } vec_t;

  localparam logic [11:0] ALL  = 12'hFFF;
  localparam logic [11:0] CORE = 12'b1110_0000_0001;  // regwrite, memwrite, pcsrc, illegal
  localparam logic [31:0] ADDI = 32'hFF718393;

  vec_t vecs[24];
  int   n_vec = 0;
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [11:0] e(input logic rw, input logic mw, input logic pc,
                                    input logic as, input logic [1:0] imm,
                                    input logic [1:0] res, input logic [2:0] alu,
                                    input logic ill);
    return {rw, mw, pc, as, imm, res, alu, ill};
  endfunction

  function automatic logic [11:0] dut_word();
    return {regwrite, memwrite, pcsrc, alusrc, immsrc, resultsrc, alucontrol, illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expct);
    n_checks++;
    if (act === expct) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expct);
  endtask

  task automatic add(input logic [31:0] i, input logic z, input logic [11:0] x,
                     input logic [11:0] m);
    vecs[n_vec] = '{instr: i, zero: z, expct: x, mask: m};
    n_vec++;
  endtask

  task automatic compare_sb();
    vec_t v;
    if (sb.size() == 0) begin
      check("scoreboard underflow", 32'd0, 32'd1);
    end else begin
      v = sb.pop_front();
      check($sformatf("decode instr=%h zero=%0b", v.instr, v.zero),
            {20'd0, dut_word() & v.mask}, {20'd0, v.expct & v.mask});
    end
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    instr = v.instr;
    zero  = v.zero;
    sb.push_back(v);
    #2;
    compare_sb();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t jal_v;

    add(32'hFF718393, 1'b0, e(1,0,0,1,2'b00,2'b00,3'b000,0), ALL);  // addi
    add(32'h0023E233, 1'b1, e(1,0,0,0,2'b00,2'b00,3'b011,0), ALL);  // or
    add(32'h40208033, 1'b0, e(1,0,0,0,2'b00,2'b00,3'b001,0), ALL);  // sub
    add(32'h0020A033, 1'b0, e(1,0,0,0,2'b00,2'b00,3'b101,0), ALL);  // slt
    add(32'h0020F033, 1'b0, e(1,0,0,0,2'b00,2'b00,3'b010,0), ALL);  // and
    add(32'h00208463, 1'b1, e(0,0,1,0,2'b10,2'b00,3'b001,0), ALL);  // beq taken
    add(32'h00208463, 1'b0, e(0,0,0,0,2'b10,2'b00,3'b001,0), ALL);  // beq not taken
    add(32'h008000EF, 1'b0, e(1,0,1,0,2'b11,2'b10,3'b000,0), ALL);  // jal
    add(32'h008000EF, 1'b1, e(1,0,1,0,2'b11,2'b10,3'b000,0), ALL);
    add(32'h0040A183, 1'b0, e(1,0,0,1,2'b00,2'b01,3'b000,0), ALL);  // lw
    add(32'hFFFFA183, 1'b1, e(1,0,0,1,2'b00,2'b01,3'b000,0), ALL);  // lw, noisy ignored bits
    add(32'h0030A223, 1'b0, e(0,1,0,1,2'b01,2'b00,3'b000,0), ALL);  // sw
    add(32'h00000000, 1'b1, e(0,0,0,0,2'b00,2'b00,3'b000,1), ALL);  // bad opcode
    add(32'h0000007F, 1'b1, e(0,0,0,0,2'b00,2'b00,3'b000,1), ALL);  // bad opcode
    add(32'h40018093, 1'b0, e(1,0,0,1,2'b00,2'b00,3'b000,0), ALL);  // addi, bit30 set stays add
    add(32'h00209033, 1'b0, e(0,0,0,0,2'b00,2'b00,3'b000,1), ALL);  // R-type funct3 001
    add(32'h0040C093, 1'b0, e(0,0,0,1,2'b00,2'b00,3'b000,1), ALL);  // I-ALU funct3 100
    add(32'h0020C463, 1'b1, e(0,0,0,0,2'b00,2'b00,3'b000,1), CORE); // branch funct3 100
`ifdef CONTROLLER_BNE_EN
    add(32'h00209463, 1'b0, e(0,0,1,0,2'b10,2'b00,3'b001,0), ALL);  // bne taken
    add(32'h00209463, 1'b1, e(0,0,0,0,2'b10,2'b00,3'b001,0), ALL);  // bne not taken
`else
    add(32'h00209463, 1'b0, e(0,0,0,0,2'b00,2'b00,3'b000,1), CORE); // bne unsupported
    add(32'h00209463, 1'b1, e(0,0,0,0,2'b00,2'b00,3'b000,1), CORE);
`endif

    // Reset state and legal stream
    reset = 1'b1;
    instr = ADDI;
    zero  = 1'b0;
    repeat (2) @(negedge clk);
    check("illegal_seen after reset", {31'd0, illegal_seen}, 32'd0);

    // Decode is not gated by reset
    jal_v = '{instr: 32'h008000EF, zero: 1'b0, expct: e(1,0,1,0,2'b11,2'b10,3'b000,0), mask: ALL};
    apply_vec(jal_v);

    @(negedge clk);
    reset = 1'b0;
    instr = ADDI;
    @(negedge clk);
    check("illegal_seen legal stream", {31'd0, illegal_seen}, 32'd0);

    // Illegal is combinational, the flag follows one edge later
    instr = 32'h00000000;
    #2;
    check("illegal comb", {31'd0, illegal}, 32'd1);
    check("illegal_seen before edge", {31'd0, illegal_seen}, 32'd0);
    @(negedge clk);
    check("illegal_seen set", {31'd0, illegal_seen}, 32'd1);

    instr = ADDI;
    #2;
    check("illegal clears on legal", {31'd0, illegal}, 32'd0);
    repeat (3) @(negedge clk);
    check("illegal_seen held", {31'd0, illegal_seen}, 32'd1);

    // Reset and illegal on the same edge: reset wins
    instr = 32'h00000000;
    reset = 1'b1;
    @(negedge clk);
    check("reset wins over illegal", {31'd0, illegal_seen}, 32'd0);
    reset = 1'b0;
    instr = ADDI;
    @(negedge clk);
    check("illegal_seen stays clear", {31'd0, illegal_seen}, 32'd0);

    for (int i = 0; i < n_vec; i++) apply_vec(vecs[i]);

    @(negedge clk);
    check("illegal_seen after table", {31'd0, illegal_seen}, 32'd1);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
